// File: rtl/serial_accum_adder_if.sv
// Pin bundle for the serial accumulating adder: operand, control, result and status lanes.
// The master side drives operand/control, the slave side (the adder) drives result/status.
interface serial_accum_adder_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/serial_accum_adder.sv
// Bit-serial accumulating adder: one operand bit per clock through two cascaded half adders,
// committing the whole sum and carry to the accumulator only on the final shift.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a start rising edge; clear zeroes acc/carry
// S_LOAD  | capture operand B and A (accumulator or 0), reset counter
// S_SHIFT | 8 serial add steps, LSB first
// S_DONE  | one-cycle done pulse, back to idle
module serial_accum_adder #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  serial_accum_adder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t         state_q;
  logic [2:0]     cnt_q;
  logic           start_prev_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic           c_q;
  logic [W-1:0]   acc_q;
  logic           carry_q;

  logic start_ev;
  logic acc_mode;
  logic clear;
  logic ha1_s, ha1_c, sum_bit, ha2_c, carry_d;
  logic busy, done;
  logic unused_inputs;

  assign start_ev = bus.uio_in[0] & ~start_prev_q;
  assign acc_mode = bus.uio_in[1];
  assign clear    = bus.uio_in[2];

  assign ha1_s   = a_q[0] ^ b_q[0];
  assign ha1_c   = a_q[0] & b_q[0];
  assign sum_bit = ha1_s ^ c_q;
  assign ha2_c   = ha1_s & c_q;
  assign carry_d = ha1_c | ha2_c;

  // ena is always high on this pin map and the upper control bits are spare.
  assign unused_inputs = ^{ena, bus.uio_in[7:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      start_prev_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      c_q          <= 1'b0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
    end else begin
      start_prev_q <= bus.uio_in[0];
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
          end else if (start_ev) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          b_q     <= bus.ui_in;
          a_q     <= acc_mode ? acc_q : '0;
          c_q     <= 1'b0;
          cnt_q   <= 3'd0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= carry_d;
          res_q <= {sum_bit, res_q[W-1:1]};
          cnt_q <= cnt_q + 3'd1;
          // Accumulator is only written here so no partial sum is ever visible.
          if (cnt_q == 3'd7) begin
            acc_q   <= {sum_bit, res_q[W-1:1]};
            carry_q <= carry_d;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

  assign bus.uo_out  = acc_q;
  assign bus.uio_out = {1'b0, carry_q, done, busy, 4'b0000};
  assign bus.uio_oe  = 8'hF0;

endmodule

// File: doc/serial_accum_adder.md
SERIAL_ACCUM_ADDER -- requirements
Module: serial_accum_adder

Interface
REQ-001 Parameter: W, 8, operand/accumulator width; only W=8 SHALL be supported on this pin map.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  always 1 when powered; SHALL be ignored.
REQ-005 ui_in  input  8  operand B, captured in LOAD state.
REQ-006 uio_in  input  8  controls: [0] start, [1] acc_mode (1 = A+B with A = accumulator, 0 = A = 0), [2] clear; [7:3] unused.
REQ-007 uo_out  output  8  accumulator value.
REQ-008 uio_out  output  8  status: [4] busy, [5] done, [6] carry flag; [3:0] and [7] tied 0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 States SHALL be IDLE, LOAD, SHIFT, DONE, with a 3-bit bit counter and a registered start_prev.
REQ-011 start_prev SHALL sample uio_in[0] on every edge, in all states; start event = uio_in[0]=1 and start_prev=0.
REQ-012 IDLE: clear=1 SHALL set accumulator=0 and carry=0 and stay IDLE; clear has priority over a start event in the same cycle.
REQ-013 IDLE: start event with clear=0 SHALL go to LOAD; otherwise stay IDLE.
REQ-014 LOAD (1 cycle): B shift reg <= ui_in; A shift reg <= accumulator if acc_mode=1 else 0; internal carry <= 0; counter <= 0; next SHIFT.
REQ-015 SHIFT (8 cycles): each edge computes s = A[0]^B[0]^c, c' = majority(A[0],B[0],c) (two cascaded half adders), shifts A and B right one bit, shifts s into result MSB, increments counter.
REQ-016 On the SHIFT edge with counter=7: accumulator <= completed result, carry flag <= final c', next DONE.
REQ-017 DONE (1 cycle): done=1, next IDLE.
REQ-018 busy SHALL be 1 exactly in LOAD and SHIFT; done exactly in DONE; both combinational decodes of state.
REQ-019 Latency: start sampled at edge E0; accumulator and carry update at E9; done high between E9 and E10; next start event accepted at E10 or later.
REQ-020 Arithmetic SHALL be modulo 256; carry flag = carry out of bit 7; carry flag holds until next completed add, clear, or reset.
REQ-021 Start events and clear outside IDLE SHALL be ignored and not queued; a start held high across an operation SHALL NOT retrigger.
REQ-022 ui_in and acc_mode SHALL be sampled only in LOAD; changes in SHIFT SHALL NOT affect the result.
REQ-023 uo_out SHALL show the old accumulator until E9 (no partial-result visibility).

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force state=IDLE, accumulator=0, carry flag=0, start_prev=0, shift regs and counter=0; uo_out=0, uio_out=0.
REQ-025 Reset during LOAD/SHIFT/DONE SHALL abort the operation; accumulator SHALL read 0 afterwards, not a partial sum.
REQ-026 After rst_n deasserts with uio_in[0] already 1, a start event SHALL occur on the first edge (start_prev=0).

Verification
REQ-027 Reset: rst_n=0 mid-cycle -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'hF0 without a clock edge.
REQ-028 Load: acc_mode=0, ui_in=8'h5A, start pulse -> busy high for 9 cycles, done one cycle, uo_out=8'h5A, carry=0.
REQ-029 Accumulate with wrap: acc=8'hFF, acc_mode=1, ui_in=8'h01, start -> uo_out=8'h00, carry=1; then ui_in=8'h03 -> 8'h03, carry=0.
REQ-030 Ignored inputs: start re-pulsed and clear=1 during SHIFT, ui_in changed after LOAD -> single done, result uses LOAD-time operand.
REQ-031 Clear vs start: in IDLE, clear=1 and start rise on the same edge -> accumulator=0, carry=0, no busy.
REQ-032 Abort: rst_n low at the 4th SHIFT cycle of acc 8'h10 + 8'h22 -> uo_out=8'h00; next op with acc_mode=0, ui_in=8'h07 gives 8'h07.
